pad_autoread: RTL and testbench

//  Hardware gamepad reader that replaces CPU bit-banging of the serial pad latch/clock lines.

---
 rtl/pad_autoread_if.sv | 19 +
 rtl/pad_autoread.sv | 143 ++++++++++++++
 tb/tb_pad_autoread.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pad_autoread_if.sv
// rtl/pad_autoread_if.sv - host register bus between the MMIO master and the pad reader
interface pad_autoread_if;
    logic [3:0]  host_address;
    logic        host_read_en;
    logic        host_write_en;
    logic [15:0] host_write_data;
    logic [15:0] host_read_data;
    logic        host_ready;

    modport master (
        output host_address, host_read_en, host_write_en, host_write_data,
        input  host_read_data, host_ready
    );

    modport slave (
        input  host_address, host_read_en, host_write_en, host_write_data,
        output host_read_data, host_ready
    );
endinterface

// File: rtl/pad_autoread.sv
// rtl/pad_autoread.sv - serial gamepad reader with latch/clock sequencing and snapshot registers
module pad_autoread #(
    parameter int PAD_COUNT    = 2,
    parameter int BITS         = 16,
    parameter int CLK_DIV      = 24,
    parameter int LATCH_CYCLES = 48
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 trigger,
    pad_autoread_if.slave        host,
    output logic                 pad_latch,
    output logic                 pad_clk,
    input  logic [PAD_COUNT-1:0] pad_data
);

    localparam int MAXC = (LATCH_CYCLES > CLK_DIV) ? LATCH_CYCLES : CLK_DIV;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int BW   = $clog2(BITS + 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_GAP, S_LOW, S_HIGH, S_DONE} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         bit_cnt;
    logic [PAD_COUNT-1:0]  sync1, sync2;
    logic [BITS-1:0]       shift_q [PAD_COUNT];
    logic [BITS-1:0]       pad_q   [PAD_COUNT];
    logic                  ctrl_auto, st_new, st_overrun;
    logic                  busy, ctrl_wr, start_req, status_rd, sample;
    logic [15:0]           rd_mux;
    logic                  unused_bits;

    assign busy        = (state != S_IDLE);
    assign ctrl_wr     = host.host_write_en && (host.host_address == 4'd0);
    assign start_req   = (trigger && ctrl_auto) || (ctrl_wr && host.host_write_data[1]);
    assign status_rd   = host.host_read_en && (host.host_address == 4'd1);
    assign unused_bits = ^host.host_write_data[15:2];

    // One sample at the end of GAP, then one per HIGH except the last: BITS in total.
    assign sample = (cnt == DIV_LAST) &&
                    ((state == S_GAP) || (state == S_HIGH && bit_cnt != BIT_LAST));

    function automatic logic [BITS-1:0] shift_in(input logic [BITS-1:0] cur, input logic b);
        logic [BITS-1:0] r;
        r = cur >> 1;
        r[BITS-1] = b;
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            pad_latch <= 1'b0;
            pad_clk   <= 1'b1;
        end else begin
            case (state)
                S_IDLE: if (start_req) begin
                    state     <= S_LATCH;
                    pad_latch <= 1'b1;
                    cnt       <= '0;
                end
                S_LATCH: if (cnt == LATCH_LAST) begin
                    state     <= S_GAP;
                    pad_latch <= 1'b0;
                    cnt       <= '0;
                end else cnt <= cnt + 1'b1;
                S_GAP: if (cnt == DIV_LAST) begin
                    state   <= S_LOW;
                    pad_clk <= 1'b0;
                    cnt     <= '0;
                    bit_cnt <= '0;
                end else cnt <= cnt + 1'b1;
                S_LOW: if (cnt == DIV_LAST) begin
                    state   <= S_HIGH;
                    pad_clk <= 1'b1;
                    cnt     <= '0;
                end else cnt <= cnt + 1'b1;
                S_HIGH: if (cnt == DIV_LAST) begin
                    cnt <= '0;
                    if (bit_cnt == BIT_LAST) begin
                        state <= S_DONE;
                    end else begin
                        state   <= S_LOW;
                        pad_clk <= 1'b0;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end else cnt <= cnt + 1'b1;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (host.host_address)
            4'd0:    rd_mux[0]   = ctrl_auto;
            4'd1:    rd_mux[2:0] = {st_overrun, st_new, busy};
            default: for (int n = 0; n < PAD_COUNT; n++)
                         if (host.host_address == 4'(n + 2)) rd_mux[BITS-1:0] = pad_q[n];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1               <= '0;
            sync2               <= '0;
            ctrl_auto           <= 1'b0;
            st_new              <= 1'b0;
            st_overrun          <= 1'b0;
            host.host_ready     <= 1'b0;
            host.host_read_data <= '0;
            for (int p = 0; p < PAD_COUNT; p++) begin
                shift_q[p] <= '0;
                pad_q[p]   <= '0;
            end
        end else begin
            sync1 <= pad_data;
            sync2 <= sync1;
            host.host_ready     <= host.host_read_en || host.host_write_en;
            host.host_read_data <= rd_mux;
            if (ctrl_wr) ctrl_auto <= host.host_write_data[0];
            // Clears come first so that same-cycle set events take priority.
            if (status_rd) begin
                st_new     <= 1'b0;
                st_overrun <= 1'b0;
            end
            if (start_req && busy) st_overrun <= 1'b1;
            if (state == S_DONE)   st_new     <= 1'b1;
            for (int p = 0; p < PAD_COUNT; p++) begin
                if (sample)          shift_q[p] <= shift_in(shift_q[p], sync2[p]);
                if (state == S_DONE) pad_q[p]   <= ~shift_q[p];
            end
        end
    end

endmodule

// File: tb/tb_pad_autoread.sv
// tb/tb_pad_autoread.sv - directed self-checking bench for pad_autoread
module tb_pad_autoread;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic trigger = 1'b0;
    logic trig_b = 1'b0;
    logic pad_latch, pad_clk, latch_b, pclk_b;
    logic [1:0] pad_data;
    logic [3:0] pad_data_b;

    pad_autoread_if hif();
    pad_autoread_if hif_b();

    pad_autoread u_dut (
        .clk(clk), .reset(reset), .trigger(trigger), .host(hif.slave),
        .pad_latch(pad_latch), .pad_clk(pad_clk), .pad_data(pad_data)
    );

    pad_autoread #(.PAD_COUNT(4), .BITS(8), .CLK_DIV(4), .LATCH_CYCLES(4)) u_dut_b (
        .clk(clk), .reset(reset), .trigger(trig_b), .host(hif_b.slave),
        .pad_latch(latch_b), .pad_clk(pclk_b), .pad_data(pad_data_b)
    );

    always #5 clk = ~clk;

    // Pad models: pin levels (low = pressed) load on latch rise, next bit on pad_clk rise.
    logic [15:0] pins0 = 16'hFFFF, pins1 = 16'hFFFF, sr0 = 16'hFFFF, sr1 = 16'hFFFF;
    logic [7:0]  pins_b [4];
    logic [7:0]  sr_b   [4];

    always @(posedge pad_latch) begin
        sr0 = pins0;
        sr1 = pins1;
    end
    always @(posedge pad_clk) if (!pad_latch) begin
        sr0 = {1'b1, sr0[15:1]};
        sr1 = {1'b1, sr1[15:1]};
    end
    assign pad_data = {sr1[0], sr0[0]};

    always @(posedge latch_b) for (int p = 0; p < 4; p++) sr_b[p] = pins_b[p];
    always @(posedge pclk_b) if (!latch_b) for (int p = 0; p < 4; p++) sr_b[p] = {1'b1, sr_b[p][7:1]};
    assign pad_data_b = {sr_b[3][0], sr_b[2][0], sr_b[1][0], sr_b[0][0]};

    int n_pass = 0;
    int n_total = 0;

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic host_wr(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        hif.host_address = a; hif.host_write_data = d; hif.host_write_en = 1'b1;
        @(negedge clk);
        hif.host_write_en = 1'b0;
    endtask

    task automatic host_rd(input logic [3:0] a, output logic [15:0] d, output logic rdy);
        @(negedge clk);
        hif.host_address = a; hif.host_read_en = 1'b1;
        @(negedge clk);
        hif.host_read_en = 1'b0;
        d = hif.host_read_data; rdy = hif.host_ready;
    endtask

    task automatic host_wr_b(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        hif_b.host_address = a; hif_b.host_write_data = d; hif_b.host_write_en = 1'b1;
        @(negedge clk);
        hif_b.host_write_en = 1'b0;
    endtask

    task automatic host_rd_b(input logic [3:0] a, output logic [15:0] d);
        @(negedge clk);
        hif_b.host_address = a; hif_b.host_read_en = 1'b1;
        @(negedge clk);
        hif_b.host_read_en = 1'b0;
        d = hif_b.host_read_data;
    endtask

    task automatic test_reset;
        logic [15:0] d; logic rdy;
        wait_cycles(3);
        n_total++; if ({pad_latch, pad_clk, hif.host_ready} !== 3'b010)
            $display("FAIL reset_pins: got latch/clk/ready %b expected 010", {pad_latch, pad_clk, hif.host_ready});
        else n_pass++;
        n_total++; if (hif.host_read_data !== 16'h0)
            $display("FAIL reset_rdata: got %h expected 0000", hif.host_read_data); else n_pass++;
        @(negedge clk) reset = 1'b0;
        host_rd(4'd1, d, rdy);
        n_total++; if ({rdy, d} !== 17'h1_0000)
            $display("FAIL reset_status: got ready %b data %h expected 1 0000", rdy, d); else n_pass++;
        host_rd(4'd2, d, rdy);
        n_total++; if (d !== 16'h0) $display("FAIL reset_pad0: got %h expected 0000", d); else n_pass++;
    endtask

    task automatic test_basic_read;
        logic [15:0] d; logic rdy;
        pins0 = 16'hA55A; pins1 = 16'hFFFF;
        host_wr(4'd0, 16'h0002);
        wait_cycles(900);
        host_rd(4'd0, d, rdy);
        n_total++; if (d !== 16'h0) $display("FAIL ctrl_start_reads0: got %h expected 0000", d); else n_pass++;
        host_rd(4'd2, d, rdy);
        n_total++; if (d !== 16'h5AA5) $display("FAIL basic_pad0: got %h expected 5aa5", d); else n_pass++;
        host_rd(4'd3, d, rdy);
        n_total++; if (d !== 16'h0000) $display("FAIL basic_pad1: got %h expected 0000", d); else n_pass++;
        host_rd(4'd1, d, rdy);
        n_total++; if (d !== 16'h0002) $display("FAIL basic_status_new: got %h expected 0002", d); else n_pass++;
        host_rd(4'd1, d, rdy);
        n_total++; if (d !== 16'h0000) $display("FAIL basic_status_clr: got %h expected 0000", d); else n_pass++;
    endtask

    task automatic test_timing;
        int latch_cnt = 0, falls = 0, cur_low = 0, bad_len = 0;
        int last_low = -1, latch_fall_k = -1, first_fall_k = -1, idle_k = -1;
        logic prev_clk = 1'b1, seen_busy = 1'b0;
        host_wr(4'd0, 16'h0002);
        hif.host_address = 4'd1; hif.host_read_en = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            if (pad_latch) latch_cnt++;
            else if (latch_cnt > 0 && latch_fall_k < 0) latch_fall_k = k;
            if (!pad_clk) begin
                if (prev_clk) begin
                    falls++; cur_low = 0;
                    if (first_fall_k < 0) first_fall_k = k;
                end
                cur_low++; last_low = k;
            end else if (!prev_clk && cur_low != 24) bad_len++;
            prev_clk = pad_clk;
            if (k >= 1) begin
                if (hif.host_read_data[0]) seen_busy = 1'b1;
                else if (seen_busy && idle_k < 0) idle_k = k - 1;
            end
            if (idle_k >= 0) break;
            @(negedge clk);
        end
        hif.host_read_en = 1'b0;
        n_total++; if (latch_cnt != 48) $display("FAIL latch_width: got %0d expected 48", latch_cnt); else n_pass++;
        n_total++; if (first_fall_k - latch_fall_k != 24)
            $display("FAIL gap_width: got %0d expected 24", first_fall_k - latch_fall_k); else n_pass++;
        n_total++; if (falls != 16) $display("FAIL clk_pulses: got %0d expected 16", falls); else n_pass++;
        n_total++; if (bad_len != 0) $display("FAIL clk_low_width: got %0d bad pulses expected 0", bad_len); else n_pass++;
        n_total++; if (idle_k < 0 || idle_k != last_low + 26)
            $display("FAIL busy_drop: got idle at %0d expected %0d", idle_k, last_low + 26); else n_pass++;
    endtask

    task automatic test_trigger;
        logic [15:0] d; logic rdy; int seen = 0;
        host_rd(4'd1, d, rdy);
        host_wr(4'd0, 16'h0000);
        @(negedge clk) trigger = 1'b1;
        @(negedge clk) trigger = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (pad_latch) seen++;
            @(negedge clk);
        end
        n_total++; if (seen != 0) $display("FAIL trig_noauto_latch: got %0d high cycles expected 0", seen); else n_pass++;
        host_rd(4'd1, d, rdy);
        n_total++; if (d !== 16'h0) $display("FAIL trig_noauto_status: got %h expected 0000", d); else n_pass++;
        host_wr(4'd0, 16'h0001);
        pins0 = 16'hFFFE; pins1 = 16'h7FFF;
        @(negedge clk);
        seen = int'(pad_latch);
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        n_total++; if ({seen[0], pad_latch} !== 2'b01)
            $display("FAIL trig_auto_start: got before/after %b expected 01", {seen[0], pad_latch}); else n_pass++;
        wait_cycles(900);
        host_rd(4'd2, d, rdy);
        n_total++; if (d !== 16'h0001) $display("FAIL trig_pad0: got %h expected 0001", d); else n_pass++;
        host_rd(4'd3, d, rdy);
        n_total++; if (d !== 16'h8000) $display("FAIL trig_pad1: got %h expected 8000", d); else n_pass++;
        host_rd(4'd1, d, rdy);
    endtask

    task automatic test_overrun;
        logic [15:0] d; logic rdy;
        pins0 = 16'h0F0F; pins1 = 16'hFFFF;
        @(negedge clk) trigger = 1'b1;
        @(negedge clk) trigger = 1'b0;
        wait_cycles(100);
        pins0 = 16'h0000;
        trigger = 1'b1;
        @(negedge clk) trigger = 1'b0;
        wait_cycles(800);
        host_rd(4'd2, d, rdy);
        n_total++; if (d !== 16'hF0F0) $display("FAIL ovr_pad0: got %h expected f0f0", d); else n_pass++;
        host_rd(4'd1, d, rdy);
        n_total++; if (d !== 16'h0006) $display("FAIL ovr_status: got %h expected 0006", d); else n_pass++;
        host_rd(4'd1, d, rdy);
        n_total++; if (d !== 16'h0000) $display("FAIL ovr_status_clr: got %h expected 0000", d); else n_pass++;
        host_wr(4'd0, 16'h0000);
        wait_cycles(900);
        host_rd(4'd2, d, rdy);
        n_total++; if (d !== 16'hF0F0) $display("FAIL ovr_pad0_late: got %h expected f0f0", d); else n_pass++;
        host_rd(4'd1, d, rdy);
        n_total++; if (d !== 16'h0000) $display("FAIL ovr_no_second: got %h expected 0000", d); else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic [15:0] d; logic rdy; int k = 0;
        pins0 = 16'hFFFF;
        host_wr(4'd0, 16'h0002);
        while (pad_clk && k < 300) begin
            @(negedge clk); k++;
        end
        n_total++; if (pad_clk !== 1'b0) $display("FAIL rst_reach_low: got pad_clk %b expected 0", pad_clk); else n_pass++;
        wait_cycles(5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_total++; if ({pad_clk, pad_latch} !== 2'b10)
            $display("FAIL rst_mid_pins: got clk/latch %b expected 10", {pad_clk, pad_latch}); else n_pass++;
        host_rd(4'd2, d, rdy);
        n_total++; if (d !== 16'h0) $display("FAIL rst_mid_pad0: got %h expected 0000", d); else n_pass++;
        host_rd(4'd1, d, rdy);
        n_total++; if (d !== 16'h0) $display("FAIL rst_mid_status: got %h expected 0000", d); else n_pass++;
        pins0 = 16'h1234;
        host_wr(4'd0, 16'h0002);
        wait_cycles(900);
        host_rd(4'd2, d, rdy);
        n_total++; if (d !== 16'hEDCB) $display("FAIL rst_after_pad0: got %h expected edcb", d); else n_pass++;
        host_rd(4'd1, d, rdy);
        n_total++; if (d !== 16'h0002) $display("FAIL rst_after_status: got %h expected 0002", d); else n_pass++;
    endtask

    task automatic test_four_pads;
        logic [15:0] d;
        logic [7:0] pressed [4];
        pressed[0] = 8'h01; pressed[1] = 8'h80; pressed[2] = 8'hFF; pressed[3] = 8'h00;
        for (int p = 0; p < 4; p++) pins_b[p] = ~pressed[p];
        host_wr_b(4'd0, 16'h0002);
        wait_cycles(120);
        for (int p = 0; p < 4; p++) begin
            host_rd_b(4'(p + 2), d);
            n_total++; if (d !== {8'h00, pressed[p]})
                $display("FAIL four_pad%0d: got %h expected %h", p, d, {8'h00, pressed[p]}); else n_pass++;
        end
        host_rd_b(4'd6, d);
        n_total++; if (d !== 16'h0) $display("FAIL four_unmapped6: got %h expected 0000", d); else n_pass++;
        host_rd_b(4'd1, d);
        n_total++; if (d !== 16'h0002) $display("FAIL four_status: got %h expected 0002", d); else n_pass++;
    endtask

    initial begin
        hif.host_address = '0; hif.host_read_en = 1'b0; hif.host_write_en = 1'b0; hif.host_write_data = '0;
        hif_b.host_address = '0; hif_b.host_read_en = 1'b0; hif_b.host_write_en = 1'b0; hif_b.host_write_data = '0;
        for (int p = 0; p < 4; p++) begin
            pins_b[p] = 8'hFF;
            sr_b[p]   = 8'hFF;
        end
        test_reset;
        test_basic_read;
        test_timing;
        test_trigger;
        test_overrun;
        test_reset_mid;
        test_four_pads;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
